// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage and its IF/ID register.
package fetch_stage_pkg;

    // Default address / instruction width.
    localparam int XLEN_DEF = 32;

    // Opcode field presented to the control unit.
    localparam int         OPCODE_W = 6;
    localparam logic [5:0] OP_RTYPE = 6'd0;

    // All-zero word doubles as the NOP / reset contents of IF/ID.
    localparam logic [31:0] NOP_INST = 32'h0;

    // Fetch FSM encoding.
    // REQ  : fetching from imem at pc.
    // HOLD : one fetched word parked in the buffer while downstream stalls.
    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: load a new entry, hold the current one, or flush it.
// With none of load/hold/flush asserted the entry turns into a bubble.
module fetch_stage_ifid
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] d_inst,
    input  logic [XLEN-1:0] d_pc4,
    output logic            valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc4
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q,  inst_d;
    logic [XLEN-1:0] pc4_q,   pc4_d;

    // Next entry: flush wins, then hold, then load; otherwise insert a bubble.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = d_inst;
            pc4_d   = d_pc4;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Register the entry; reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= XLEN'(NOP_INST);
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid = valid_q;
    assign inst  = inst_q;
    assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, stall hold buffer and imem handshake,
// feeding the IF/ID register and the opcode field of the control unit.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [XLEN-1:0]     imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     branch_target,
    output logic                ifid_valid,
    output logic [XLEN-1:0]     ifid_inst,
    output logic [XLEN-1:0]     ifid_pc4,
    output logic [OPCODE_W-1:0] opcode
);

    // Clears the two low address bits so every fetch is word aligned.
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [0:0]      state_q,    state_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] buf_inst_q, buf_inst_d;
    logic [XLEN-1:0] buf_pc4_q,  buf_pc4_d;

    logic            ld, hd, fl;
    logic [XLEN-1:0] ld_inst, ld_pc4;
    logic [XLEN-1:0] pc_plus4;

    // Wraps modulo 2^XLEN by construction of the width.
    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-state, PC and IF/ID control. A branch overrides stall and any
    // imem response in the same cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_inst_d = buf_inst_q;
        buf_pc4_d  = buf_pc4_q;
        ld         = 1'b0;
        hd         = 1'b0;
        fl         = 1'b0;
        ld_inst    = imem_rdata;
        ld_pc4     = pc_plus4;

        if (branch_taken) begin
            pc_d       = branch_target & WORD_MASK;
            fl         = 1'b1;
            buf_inst_d = '0;
            buf_pc4_d  = '0;
            state_d    = ST_REQ;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_ready) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            // Downstream is busy: park the word and stop fetching.
                            buf_inst_d = imem_rdata;
                            buf_pc4_d  = pc_plus4;
                            hd         = 1'b1;
                            state_d    = ST_HOLD;
                        end else begin
                            ld = 1'b1;
                        end
                    end else begin
                        // No data: bubble unless downstream wants IF/ID frozen.
                        hd = stall;
                    end
                end
                ST_HOLD: begin
                    // imem_ready is not looked at here: no request is outstanding.
                    if (stall) begin
                        hd = 1'b1;
                    end else begin
                        ld      = 1'b1;
                        ld_inst = buf_inst_q;
                        ld_pc4  = buf_pc4_q;
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // PC, FSM and hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            buf_inst_q <= '0;
            buf_pc4_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc4_q  <= buf_pc4_d;
        end
    end

    fetch_stage_ifid #(
        .XLEN (XLEN)
    ) u_ifid (
        .clk    (clk),
        .rst    (rst),
        .load   (ld),
        .hold   (hd),
        .flush  (fl),
        .d_inst (ld_inst),
        .d_pc4  (ld_pc4),
        .valid  (ifid_valid),
        .inst   (ifid_inst),
        .pc4    (ifid_pc4)
    );

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign opcode    = ifid_valid ? ifid_inst[XLEN-1 -: OPCODE_W] : OP_RTYPE;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch pipeline.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h40;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ifid_valid;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic [5:0]  opcode;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ifid_valid    (ifid_valid),
        .ifid_inst     (ifid_inst),
        .ifid_pc4      (ifid_pc4),
        .opcode        (opcode)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ (a << 13) ^ 32'hA5C3_0F17;
    endfunction

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_0020;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        #2;
        n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h exp 0", ifid_valid); end
        n_tests++; if (ifid_inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got %h exp 0", ifid_inst); end
        n_tests++; if (ifid_pc4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4 got %h exp 0", ifid_pc4); end
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req got %h exp 1", imem_req); end
        n_tests++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL rst_addr got %h exp %h", imem_addr, RPC); end
        n_tests++; if (opcode !== 6'd0) begin n_fail++; $display("FAIL rst_opcode got %h exp 0", opcode); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %h exp 1", ifid_valid); end
        n_tests++; if (ifid_inst !== 32'h20) begin n_fail++; $display("FAIL first_inst got %h exp 20", ifid_inst); end
        n_tests++; if (ifid_pc4 !== 32'h44) begin n_fail++; $display("FAIL first_pc4 got %h exp 44", ifid_pc4); end
        n_tests++; if (opcode !== 6'd0) begin n_fail++; $display("FAIL first_opcode got %h exp 0", opcode); end
        n_tests++; if (imem_addr !== 32'h44) begin n_fail++; $display("FAIL first_addr got %h exp 44", imem_addr); end
    endtask

    task automatic test_not_ready();
        branch_taken = 1'b1; branch_target = 32'h8;
        tick();
        branch_taken = 1'b0; imem_ready = 1'b0; stall = 1'b0;
        n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL br8_addr got %h exp 8", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL nr_addr[%0d] got %h exp 8", i, imem_addr); end
            n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL nr_valid[%0d] got %h exp 0", i, ifid_valid); end
        end
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        n_tests++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL nr_done_valid got %h exp 1", ifid_valid); end
        n_tests++; if (ifid_pc4 !== 32'hC) begin n_fail++; $display("FAIL nr_done_pc4 got %h exp c", ifid_pc4); end
        n_tests++; if (ifid_inst !== 32'h1234_5678) begin n_fail++; $display("FAIL nr_done_inst got %h exp 12345678", ifid_inst); end
    endtask

    task automatic test_stall_hold();
        // pc is 0xC; IF/ID holds 0x12345678 / 0xC.
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h8C01_0004;
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req got %h exp 0", imem_req); end
        n_tests++; if (ifid_inst !== 32'h1234_5678) begin n_fail++; $display("FAIL hold_inst got %h exp 12345678", ifid_inst); end
        n_tests++; if (ifid_pc4 !== 32'hC) begin n_fail++; $display("FAIL hold_pc4 got %h exp c", ifid_pc4); end
        tick();
        n_tests++; if (ifid_inst !== 32'h1234_5678 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL hold2 got %h/%h exp 12345678/1", ifid_inst, ifid_valid); end
        stall = 1'b0; imem_ready = 1'b0;
        tick();
        n_tests++; if (ifid_inst !== 32'h8C01_0004) begin n_fail++; $display("FAIL unhold_inst got %h exp 8c010004", ifid_inst); end
        n_tests++; if (ifid_pc4 !== 32'h10) begin n_fail++; $display("FAIL unhold_pc4 got %h exp 10", ifid_pc4); end
        n_tests++; if (opcode !== 6'h23) begin n_fail++; $display("FAIL unhold_opcode got %h exp 23", opcode); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL unhold_addr got %h/%h exp 1/10", imem_req, imem_addr); end
    endtask

    task automatic test_branch_flush();
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0001;
        tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL brh_req got %h exp 0", imem_req); end
        branch_taken = 1'b1; branch_target = 32'h103; imem_rdata = 32'hBAD0_0002;
        tick();
        branch_taken = 1'b0;
        n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid got %h exp 0", ifid_valid); end
        n_tests++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin n_fail++; $display("FAIL br_addr got %h/%h exp 100/1", imem_addr, imem_req); end
        stall = 1'b0; imem_ready = 1'b0;
        tick();
        n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL br_nobuf got %h exp 0", ifid_valid); end
        imem_ready = 1'b1; imem_rdata = 32'h0404_0404;
        tick();
        n_tests++; if (ifid_inst !== 32'h0404_0404 || ifid_pc4 !== 32'h104) begin n_fail++; $display("FAIL br_next got %h/%h exp 04040404/104", ifid_inst, ifid_pc4); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE; imem_ready = 1'b0;
        tick();
        branch_taken = 1'b0;
        n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h exp fffffffc", imem_addr); end
        imem_ready = 1'b1; imem_rdata = 32'hFC00_0000;
        tick();
        n_tests++; if (ifid_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h exp 0", ifid_pc4); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
        n_tests++; if (opcode !== 6'h3F) begin n_fail++; $display("FAIL wrap_opcode got %h exp 3f", opcode); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h7777_0000;
        tick();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ar_pre_req got %h exp 0", imem_req); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %h exp 0", ifid_valid); end
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ar_req got %h exp 1", imem_req); end
        n_tests++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL ar_addr got %h exp %h", imem_addr, RPC); end
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        tick();
    endtask

    // Randomized run checked against a queue model: the queue holds at most
    // one fetched-but-not-delivered word, and fetching pauses while it is full.
    task automatic test_random();
        logic [31:0] m_pc, m_inst, m_pc4;
        logic        m_valid;
        logic [63:0] q[$];
        logic        r, s, b;
        logic [31:0] t, rd;
        logic [5:0]  exp_op;
        int          bad;

        rst = 1'b1; #1 rst = 1'b0;
        m_pc = RPC; m_valid = 1'b0; m_inst = '0; m_pc4 = '0; q.delete();
        bad = 0;
        for (int c = 0; c < 2000; c++) begin
            exp_op = m_valid ? m_inst[31:26] : 6'd0;
            n_tests++;
            if (imem_req !== (q.size() == 0) || imem_addr !== m_pc || ifid_valid !== m_valid ||
                (m_valid && (ifid_inst !== m_inst || ifid_pc4 !== m_pc4)) || opcode !== exp_op) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL rand[%0d] got req=%h addr=%h v=%h i=%h p=%h op=%h exp req=%h addr=%h v=%h i=%h p=%h op=%h",
                             c, imem_req, imem_addr, ifid_valid, ifid_inst, ifid_pc4, opcode,
                             (q.size() == 0), m_pc, m_valid, m_inst, m_pc4, exp_op);
                bad++;
            end
            r = ($urandom_range(99) < 70);
            s = ($urandom_range(99) < 30);
            b = ($urandom_range(99) < 6);
            t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            rd = mem_word(m_pc);
            imem_ready = r; stall = s; branch_taken = b; branch_target = t; imem_rdata = rd;
            tick();
            if (b) begin
                m_pc = t & 32'hFFFF_FFFC; m_valid = 1'b0; q.delete();
            end else if (q.size() != 0) begin
                if (!s) begin {m_inst, m_pc4} = q.pop_front(); m_valid = 1'b1; end
            end else if (r) begin
                if (s) q.push_back({rd, m_pc + 32'd4});
                else begin m_valid = 1'b1; m_inst = rd; m_pc4 = m_pc + 32'd4; end
                m_pc = m_pc + 32'd4;
            end else if (!s) begin
                m_valid = 1'b0;
            end
        end
        imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_not_ready();
        test_stall_hold();
        test_branch_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register, sitting directly upstream of the main control unit.
- Holds the PC and issues word fetches to instruction memory through a req/ready handshake.
- Captures each returned instruction into IF/ID, tracking PC+4 and a valid bit.
- Drives the opcode field to the control unit.
- Handles downstream stall and branch redirect/flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address (current PC).
- imem_ready  in  1  imem_rdata is valid for imem_addr in this cycle.
- imem_rdata  in  XLEN  fetched instruction word.
- stall  in  1  downstream cannot accept a new IF/ID entry; hold IF/ID.
- branch_taken  in  1  redirect fetch and flush IF/ID.
- branch_target  in  XLEN  redirect address.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_inst  out  XLEN  registered instruction.
- ifid_pc4  out  XLEN  registered PC+4 of that instruction.
- opcode  out  6  ifid_inst[31:26]; forced to 6'd0 when ifid_valid=0.

Behaviour:
Reset (async, rst=1):
- pc=RESET_PC, state=REQ, ifid_valid=0, ifid_inst=0, ifid_pc4=0, hold buffer=0.
- Outputs combinational from reset state: imem_req=1 in REQ, imem_addr=RESET_PC, opcode=0.

Memory protocol:
- imem_addr may change while imem_req=1 and imem_ready=0.
- Memory returns data for the address presented in the imem_ready cycle.
- imem_ready is ignored when imem_req=0.

State REQ (imem_req=1, imem_addr=pc):
- imem_ready=1, stall=0: IF/ID <= {1, imem_rdata, pc+4}; pc <= pc+4; stay REQ.
- imem_ready=1, stall=1: buffer <= {imem_rdata, pc+4}; pc <= pc+4; go HOLD. IF/ID unchanged.
- imem_ready=0: pc unchanged. If stall=0, ifid_valid <= 0 (bubble). If stall=1, IF/ID held.

State HOLD (imem_req=0):
- stall=1: all state held.
- stall=0: IF/ID <= {1, buffer}; go REQ.

Branch (branch_taken=1, any state) has priority over stall and imem_ready:
- pc <= {branch_target[31:2], 2'b00}.
- ifid_valid <= 0.
- Buffer discarded; go REQ.
- Any imem response in that cycle is dropped.

Latency and throughput:
- With imem_ready held high, the first valid IF/ID entry appears one edge after reset release.
- Throughput is one instruction per cycle.

Arithmetic:
- pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.

While stall=1, ifid_inst, ifid_pc4 and ifid_valid are bit-stable unless branch_taken=1.

Decomposition:
- Shared package: XLEN default; OPCODE_W=6; OP_RTYPE=6'd0; NOP_INST=32'h0; fetch state encoding (REQ, HOLD).
- Natural sub-module ifid_reg: the IF/ID register with load, hold and flush inputs.
- fetch_stage keeps the PC, FSM, hold buffer and imem interface.

Test Plan:
1. Reset with RESET_PC=32'h40, imem_ready=1, imem_rdata=32'h0000_0020 -> one edge after reset release: ifid_valid=1, ifid_inst=32'h20, ifid_pc4=32'h44, opcode=0, imem_addr=32'h44.
2. imem_ready low 3 cycles at pc=8, stall=0 -> imem_addr stays 8, ifid_valid=0 for those cycles; on ready, ifid_pc4=32'hC.
3. stall=1 while ready returns 32'h8C01_0004 -> state HOLD, imem_req=0, IF/ID unchanged; stall drops -> ifid_inst=32'h8C01_0004 next edge.
4. branch_taken=1, branch_target=32'h103, concurrent with stall=1 and imem_ready=1 -> ifid_valid=0, imem_addr=32'h100 next cycle, buffered instruction never appears.
5. pc=32'hFFFF_FFFC fetch with ready=1 -> ifid_pc4=0, next imem_addr=0.
6. Assert rst mid-HOLD -> immediately ifid_valid=0, imem_req=1, imem_addr=RESET_PC without waiting for clk.
